// File: rtl/platypus_ft_pkg.sv
// Shared definitions for the FT2232H FT245 synchronous FIFO interface blocks.
package platypus_ft_pkg;

    localparam int FT_DATA_W = 8;

    // FT2232H control strobes are active-low.
    localparam logic FT_ASSERT   = 1'b0;
    localparam logic FT_DEASSERT = 1'b1;

    // Receive sequencer: IDLE -> OE (bus turnaround) -> READ (strobing bytes).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        READ = 2'd2
    } ft_rx_state_e;

endpackage

// File: rtl/ft_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO. Head of queue is visible on
// dout whenever the FIFO is non-empty; dout reads as zero while empty.
module ft_rx_fifo
    import platypus_ft_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 push,
    input  logic                 pop,
    input  logic [FT_DATA_W-1:0] din,
    output logic [FT_DATA_W-1:0] dout,
    output logic [ADDR_W:0]      count,
    output logic                 empty,
    output logic                 full
);

    logic [FT_DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Next pointer values; a pop on an empty FIFO is ignored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
        end
    end

`ifndef SYNTHESIS
    // The receive sequencer drops RD# on the filling edge, so a push into a
    // full FIFO without a simultaneous pop must never happen.
    assert property (@(posedge clk_i) disable iff (reset_i) !(push && full && !pop));
`endif

endmodule

// File: rtl/ft245_sync_rx.sv
// FT245 synchronous FIFO receive path (host -> FPGA) in the 60 MHz FT clock
// domain. Drives OE#/RD#, captures ADBUS into an FWFT FIFO and presents the
// bytes on a valid/ready stream.
// Optional build macro FT_RX_STATS_EN adds rx_bytes_o and rx_stall_o counters.
module ft245_sync_rx
    import platypus_ft_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 ft_rxf_i,
    input  logic [FT_DATA_W-1:0] ft_data_i,
    output logic                 ft_oe_o,
    output logic                 ft_rd_o,
    output logic [FT_DATA_W-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [ADDR_W:0]      fifo_count_o
`ifdef FT_RX_STATS_EN
    ,
    output logic [31:0]          rx_bytes_o,
    output logic [15:0]          rx_stall_o
`endif
);

    ft_rx_state_e    state_q, state_d;
    logic            oe_q, oe_d;
    logic            rd_q, rd_d;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [ADDR_W:0] fifo_count;
    logic [ADDR_W:0] free_space;
    logic            room_ok;
    logic [ADDR_W+1:0] post_count;

    // A byte is on the bus and strobed whenever our registered RD# is low
    // while the FT2232H still reports data available.
    assign push = (rd_q == FT_ASSERT) && (ft_rxf_i == FT_ASSERT);
    assign pop  = !fifo_empty && m_ready_i;

    // Fill level after the coming edge; the burst ends on the edge that fills.
    assign post_count = (ADDR_W+2)'(fifo_count) + (ADDR_W+2)'(push) - (ADDR_W+2)'(pop);
    assign free_space = (ADDR_W+1)'(DEPTH) - fifo_count;
    // A burst needs two free slots: one for the edge RD# falls, one margin.
    assign room_ok    = !fifo_full && (free_space >= (ADDR_W+1)'(2));

    ft_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .pop     (pop),
        .din     (ft_data_i),
        .dout    (m_data_o),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign m_valid_o    = !fifo_empty;
    assign fifo_count_o = fifo_count;
    assign ft_oe_o      = oe_q;
    assign ft_rd_o      = rd_q;

    // Next state and next strobe levels; strobes follow the next state so the
    // FT outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        oe_d    = FT_DEASSERT;
        rd_d    = FT_DEASSERT;
        case (state_q)
            IDLE: begin
                if (en_i && (ft_rxf_i == FT_ASSERT) && room_ok) begin
                    state_d = OE;
                    oe_d    = FT_ASSERT;
                end
            end
            OE: begin
                state_d = READ;
                oe_d    = FT_ASSERT;
                rd_d    = FT_ASSERT;
            end
            READ: begin
                if ((ft_rxf_i == FT_DEASSERT) || !en_i ||
                    (post_count == (ADDR_W+2)'(DEPTH))) begin
                    state_d = IDLE;
                end else begin
                    oe_d = FT_ASSERT;
                    rd_d = FT_ASSERT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and strobe registers; reset releases the bus immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            oe_q    <= FT_DEASSERT;
            rd_q    <= FT_DEASSERT;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            rd_q    <= rd_d;
        end
    end

`ifdef FT_RX_STATS_EN
    logic [31:0] rx_bytes_q, rx_bytes_d;
    logic [15:0] rx_stall_q, rx_stall_d;

    // Byte counter wraps; stall counter saturates at all-ones.
    always_comb begin
        rx_bytes_d = rx_bytes_q + (push ? 32'd1 : 32'd0);
        rx_stall_d = rx_stall_q;
        if ((state_q == IDLE) && (ft_rxf_i == FT_ASSERT) && en_i && !room_ok &&
            (rx_stall_q != 16'hFFFF)) begin
            rx_stall_d = rx_stall_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_bytes_q <= '0;
            rx_stall_q <= '0;
        end else begin
            rx_bytes_q <= rx_bytes_d;
            rx_stall_q <= rx_stall_d;
        end
    end

    assign rx_bytes_o = rx_bytes_q;
    assign rx_stall_o = rx_stall_q;
`endif

endmodule
